carregador_programa_uart: RTL and testbench
===========================================

// Module: carregador_programa_uart
// PURPOSE
//  Serial boot loader: the write side of the instruction memory that the datapath only reads.
//  - Receives a program over UART (8N1, LSB first) and assembles 32-bit words.
//  - Writes each word into instruction memory.
//  - Holds the processor (pc, register file, data memory) stalled until the full image is loaded.
//  - Sits beside memoria_de_instrucao; on the FPGA it runs on the divided clk, like the datapath.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200); must be >= 4
//  ADDR_W        8    instruction-memory word-address width; capacity 2**ADDR_W words
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  uart_rx    in   1   serial input, idle high, asynchronous to clk
//  mem_we     out  1   one-cycle write strobe to instruction memory
//  mem_addr   out  32  byte address of the word being written (word_idx<<2), matches pc width
//  mem_wdata  out  32  instruction word being written
//  cpu_hold   out  1   1 = processor must not advance pc nor write state
//  done       out  1   sticky: image fully loaded
//  err        out  1   sticky: framing error or length overflow
// BEHAVIOUR
//  - Reset (async assert, sync deassert through a 2-flop reset synchroniser):
//    mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, FSM=LEN_HI.
//    Reset mid-transfer aborts the load; memory already written is not cleared.
//  - Receiver: uart_rx passes a 2-flop synchroniser.
//    - A 1->0 edge starts a frame; after CLKS_PER_BIT/2 cycles the line is re-checked.
//    - If the line is high, the edge is a glitch and the frame is dropped silently.
//    - 8 data bits are then sampled at mid-bit every CLKS_PER_BIT cycles.
//    - Stop bit sampled 0 -> framing error.
//    - A good frame gives rx_valid for 1 cycle with rx_byte.
//  - Protocol: 2-byte big-endian word count N, then N words, each big-endian (MSB byte first).
//  - FSM states:
//    - LEN_HI -> LEN_LO: on rx_valid, store N[15:8].
//    - LEN_LO: on rx_valid, store N[7:0].
//      - N==0 -> DONE.
//      - N > 2**ADDR_W -> ERROR.
//      - else -> DATA, byte_idx=0, word_idx=0.
//    - DATA: shift rx_byte into a 32-bit assembly register.
//      On the 4th byte -> WRITE. The next cycle has mem_we=1, mem_wdata=word, mem_addr=word_idx<<2.
//    - WRITE (1 cycle): word_idx++.
//      - word_idx+1 == N -> DONE.
//      - else -> DATA.
//    - DONE: done=1, cpu_hold=0 from the same cycle. All further uart_rx traffic is ignored until reset.
//    - ERROR: err=1, cpu_hold stays 1, mem_we never asserts. Leaves only on reset.
//  - Framing error in any state except DONE -> ERROR.
//  - A new start edge is accepted no earlier than the stop-bit sample point, so back-to-back frames work.
//  - Latency: mem_we asserts exactly 1 clk after rx_valid of the 4th byte of each word.
//  - mem_addr/mem_wdata hold their last values outside the write strobe.
//  - Counter widths: word_idx is ADDR_W+1 bits, so N == 2**ADDR_W cannot wrap. byte_idx is 2 bits.
//  - No simultaneous write and byte arrival: a byte lasts at least 10*CLKS_PER_BIT cycles, and WRITE lasts 1.
// STRUCTURE
//  - Shared package/include (carregador_defs.vh):
//    - FSM state encodings: LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
//    - Default CLKS_PER_BIT.
//  - One sub-module: uart_rx_byte (synchroniser, bit-timing counter, glitch check, rx_valid/rx_byte/frame_err).
//  - The top FSM, counters and output registers live in carregador_programa_uart.
//  - At integration, the memory write port is muxed into memoria_de_instrucao.
//    cpu_hold gates the pc enable and the write enables of banco_registrador and memoria_de_dados.
// TESTING (CLKS_PER_BIT=16, ADDR_W=4 for speed)
//  1. Reset, idle line -> cpu_hold=1, done=0, err=0, mem_we never asserts for 1000 cycles.
//  2. Send 00 02 | 20 08 00 05 | 01 09 50 20
//     -> mem_we pulses twice: (addr 0x0, 0x20080005) then (addr 0x4, 0x01095020).
//     done=1 and cpu_hold=0 in the cycle after the second write.
//  3. Send 00 00 -> done=1 right after the 2nd byte, no mem_we.
//     Further bytes are ignored: mem_we stays 0.
//  4. Send 00 11 (17 > 16) -> err=1, cpu_hold=1, no writes.
//     Send 00 10 followed by 16 words -> all 16 written, last at addr 0x3C, done=1.
//  5. Frame with stop bit 0 during the 3rd data byte -> err=1, no write for that word.
//     A 0.3-bit low glitch on an idle line -> no byte, no error.
//  6. Assert rst_n=0 mid-word 1 of N=2 -> all outputs at reset values immediately.
//     Resending the full image afterwards -> correct writes, done=1.

Source files
------------

// File: rtl/carregador_programa_uart_pkg.sv
// Shared definitions for the UART boot loader: loader and receiver state
// encodings plus the default bit timing and memory size.
package carregador_programa_uart_pkg;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
   localparam int unsigned DEFAULT_ADDR_W       = 8;

   typedef enum logic [2:0] {
      LEN_HI,
      LEN_LO,
      DATA,
      WRITE,
      DONE,
      ERROR
   } loader_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

endpackage

// File: rtl/carregador_programa_uart_rx_byte.sv
// 8N1 UART byte receiver: input synchroniser, mid-bit sampling, start-bit
// glitch rejection, one-cycle rx_valid_o / frame_err_o pulses.
module uart_rx_byte
   import carregador_programa_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic       rx_valid_o,
   output logic [7:0] rx_byte_o,
   output logic       frame_err_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   rx_state_e        state_q, state_d;
   logic             rxMeta_q, rxSync_q, rxPrev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bitIdx_q, bitIdx_d;
   logic [7:0]       shift_q, shift_d;
   logic             valid_q, valid_d;
   logic             ferr_q, ferr_d;

   // Line resets to idle-high so releasing reset never fakes a start edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
         state_q  <= RX_IDLE;
         cnt_q    <= '0;
         bitIdx_q <= '0;
         shift_q  <= '0;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         rxMeta_q <= rx_i;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitIdx_q <= bitIdx_d;
         shift_q  <= shift_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bitIdx_d = bitIdx_q;
      shift_d  = shift_q;
      valid_d  = 1'b0;
      ferr_d   = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (rxPrev_q && !rxSync_q) state_d = RX_START;
         end
         RX_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d    = '0;
               bitIdx_d = '0;
               state_d  = rxSync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d    = '0;
               shift_d  = {rxSync_q, shift_q[7:1]};
               bitIdx_d = bitIdx_q + 1'b1;
               if (bitIdx_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == BIT_LAST) begin
               state_d = RX_IDLE;
               valid_d = rxSync_q;
               ferr_d  = !rxSync_q;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign rx_valid_o  = valid_q;
   assign rx_byte_o   = shift_q;
   assign frame_err_o = ferr_q;

endmodule

// File: rtl/carregador_programa_uart.sv
// Serial boot loader: receives a length-prefixed big-endian program image over
// UART, writes it into instruction memory and holds the CPU until it is loaded.
module carregador_programa_uart
   import carregador_programa_uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned ADDR_W       = DEFAULT_ADDR_W
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        uart_rx_i,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        cpu_hold_o,
   output logic        done_o,
   output logic        err_o
);

   localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;
   localparam int unsigned ADDR_PAD = 32 - ADDR_W - 2;

   logic [1:0]      rstPipe_q;
   logic            rstSyncN;
   logic            rxValid, frameErr;
   logic [7:0]      rxByte;
   logic [15:0]     lenNext;

   loader_state_e   state_q, state_d;
   logic [7:0]      lenHi_q, lenHi_d;
   logic [15:0]     len_q, len_d;
   logic [1:0]      byteIdx_q, byteIdx_d;
   logic [ADDR_W:0] wordIdx_q, wordIdx_d;
   logic [23:0]     asm_q, asm_d;
   logic [31:0]     memAddr_q, memAddr_d;
   logic [31:0]     memWdata_q, memWdata_d;

   // Reset asserts asynchronously but releases only after two clean clock edges.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rstPipe_q <= 2'b00;
      else         rstPipe_q <= {rstPipe_q[0], 1'b1};
   end
   assign rstSyncN = rstPipe_q[1];

   uart_rx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uRx (
      .clk_i      (clk_i),
      .rst_ni     (rstSyncN),
      .rx_i       (uart_rx_i),
      .rx_valid_o (rxValid),
      .rx_byte_o  (rxByte),
      .frame_err_o(frameErr)
   );

   assign lenNext = {lenHi_q, rxByte};

   always_ff @(posedge clk_i or negedge rstSyncN) begin
      if (!rstSyncN) begin
         state_q    <= LEN_HI;
         lenHi_q    <= '0;
         len_q      <= '0;
         byteIdx_q  <= '0;
         wordIdx_q  <= '0;
         asm_q      <= '0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
      end else begin
         state_q    <= state_d;
         lenHi_q    <= lenHi_d;
         len_q      <= len_d;
         byteIdx_q  <= byteIdx_d;
         wordIdx_q  <= wordIdx_d;
         asm_q      <= asm_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
      end
   end

   // Only the first three bytes of a word are buffered; the fourth completes it directly.
   always_comb begin
      state_d    = state_q;
      lenHi_d    = lenHi_q;
      len_d      = len_q;
      byteIdx_d  = byteIdx_q;
      wordIdx_d  = wordIdx_q;
      asm_d      = asm_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      if (frameErr && state_q != DONE) begin
         state_d = ERROR;
      end else begin
         unique case (state_q)
            LEN_HI: begin
               if (rxValid) begin
                  lenHi_d = rxByte;
                  state_d = LEN_LO;
               end
            end
            LEN_LO: begin
               if (rxValid) begin
                  len_d = lenNext;
                  if (lenNext == 16'd0) begin
                     state_d = DONE;
                  end else if ({1'b0, lenNext} > CAPACITY) begin
                     state_d = ERROR;
                  end else begin
                     state_d   = DATA;
                     byteIdx_d = '0;
                     wordIdx_d = '0;
                  end
               end
            end
            DATA: begin
               if (rxValid) begin
                  asm_d     = {asm_q[15:0], rxByte};
                  byteIdx_d = byteIdx_q + 1'b1;
                  if (byteIdx_q == 2'd3) begin
                     memWdata_d = {asm_q, rxByte};
                     memAddr_d  = {{ADDR_PAD{1'b0}}, wordIdx_q[ADDR_W-1:0], 2'b00};
                     state_d    = WRITE;
                  end
               end
            end
            WRITE: begin
               wordIdx_d = wordIdx_q + 1'b1;
               state_d   = (16'(wordIdx_q) + 16'd1 == len_q) ? DONE : DATA;
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = ERROR;
         endcase
      end
   end

   assign mem_we_o    = (state_q == WRITE);
   assign mem_addr_o  = memAddr_q;
   assign mem_wdata_o = memWdata_q;
   assign done_o      = (state_q == DONE);
   assign cpu_hold_o  = (state_q != DONE);
   assign err_o       = (state_q == ERROR);

endmodule

// File: tb/tb_carregador_programa_uart.sv
// Scoreboard bench for the UART boot loader: stimulus pushes expected writes
// from an image-level model, an independent monitor pops them on each strobe.
module tb_carregador_programa_uart;

   localparam int CPB = 16;
   localparam int AW  = 4;

   typedef logic [7:0] byteq_t[$];
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        uart_rx = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;

   wr_t expQ[$];
   int  compared = 0;
   int  mismatched = 0;
   bit  pendingDoneCheck = 1'b0;
   bit  expDoneAfterLast = 1'b0;

   carregador_programa_uart #(
      .CLKS_PER_BIT(CPB),
      .ADDR_W      (AW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .uart_rx_i  (uart_rx),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_wdata_o(mem_wdata),
      .cpu_hold_o (cpu_hold),
      .done_o     (done),
      .err_o      (err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   wr_t head;
   always @(negedge clk) begin
      if (pendingDoneCheck) begin
         pendingDoneCheck = 1'b0;
         checkOutput("done_after_last_write", {31'd0, done}, {31'd0, expDoneAfterLast});
         checkOutput("hold_after_last_write", {31'd0, cpu_hold}, {31'd0, !expDoneAfterLast});
      end
      if (rst_n && mem_we) begin
         if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected none",
                     mem_addr, mem_wdata);
         end else begin
            head = expQ.pop_front();
            checkOutput("write_addr", mem_addr, head.addr);
            checkOutput("write_data", mem_wdata, head.data);
            if (expQ.size() == 0) pendingDoneCheck = 1'b1;
         end
      end
   end

   task automatic waitClocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, input bit goodStop = 1'b1);
      uart_rx = 1'b0;
      waitClocks(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         waitClocks(CPB);
      end
      uart_rx = goodStop;
      waitClocks(CPB);
      uart_rx = 1'b1;
      if (!goodStop) waitClocks(CPB);
   endtask

   // Reference model: parses a byte image and predicts writes and final status.
   task automatic modelImage(input byteq_t bs, output bit expDone, output bit expErr);
      int n;
      int words;
      wr_t w;
      expDone = 1'b0;
      expErr  = 1'b0;
      if (bs.size() < 2) return;
      n = {bs[0], bs[1]};
      if (n == 0) begin
         expDone = 1'b1;
      end else if (n > (1 << AW)) begin
         expErr = 1'b1;
      end else begin
         words = (bs.size() - 2) / 4;
         if (words > n) words = n;
         for (int k = 0; k < words; k++) begin
            w.addr = 32'(k * 4);
            w.data = {bs[2 + 4*k], bs[3 + 4*k], bs[4 + 4*k], bs[5 + 4*k]};
            expQ.push_back(w);
         end
         expDone = (words == n);
      end
   endtask

   task automatic applyStimulus(input byteq_t bs, output bit expDone, output bit expErr);
      modelImage(bs, expDone, expErr);
      expDoneAfterLast = expDone;
      foreach (bs[i]) sendByte(bs[i]);
      waitClocks(4 * CPB);
   endtask

   task automatic checkStatus(input string tag, input bit expDone, input bit expErr);
      checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, expDone});
      checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, expErr});
      checkOutput({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, !expDone});
      checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_we"}, {31'd0, mem_we}, 32'd0);
      checkOutput({tag, "_addr"}, mem_addr, 32'd0);
      checkOutput({tag, "_wdata"}, mem_wdata, 32'd0);
      checkOutput({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   task automatic doReset();
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      expQ.delete();
      waitClocks(3);
      rst_n = 1'b1;
      waitClocks(4);
   endtask

   function automatic byteq_t randomImage(input int n);
      byteq_t q;
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom_range(0, 255)));
      return q;
   endfunction

   initial begin
      byteq_t bs;
      byteq_t part;
      bit     eDone;
      bit     eErr;

      // 1: reset and idle line
      #1;
      checkResetState("reset");
      doReset();
      waitClocks(1000);
      checkStatus("idle", 1'b0, 1'b0);

      // 2: two-word image from the example
      bs = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
      applyStimulus(bs, eDone, eErr);
      checkStatus("two_words", eDone, eErr);

      // 3: empty image, trailing traffic ignored
      doReset();
      bs = '{8'h00, 8'h00};
      applyStimulus(bs, eDone, eErr);
      checkStatus("empty", eDone, eErr);
      for (int i = 0; i < 4; i++) sendByte(8'($urandom_range(0, 255)));
      waitClocks(2 * CPB);
      checkStatus("empty_after_traffic", 1'b1, 1'b0);

      // 4a: length overflow
      doReset();
      bs = '{8'h00, 8'h11};
      applyStimulus(bs, eDone, eErr);
      checkStatus("overflow", eDone, eErr);
      for (int i = 0; i < 4; i++) sendByte(8'($urandom_range(0, 255)));
      waitClocks(2 * CPB);
      checkStatus("overflow_after_traffic", 1'b0, 1'b1);

      // 4b: full capacity
      doReset();
      bs = randomImage(1 << AW);
      applyStimulus(bs, eDone, eErr);
      checkStatus("full", eDone, eErr);
      checkOutput("full_last_addr", mem_addr, 32'h3C);

      // 5a: framing error on the third byte of the second word
      doReset();
      bs = randomImage(2);
      part = bs[0:7];
      modelImage(part, eDone, eErr);
      expDoneAfterLast = 1'b0;
      for (int i = 0; i < 8; i++) sendByte(bs[i]);
      sendByte(bs[8], 1'b0);
      sendByte(bs[9]);
      waitClocks(4 * CPB);
      checkStatus("frame_err", 1'b0, 1'b1);

      // 5b: short glitch must not produce a byte
      doReset();
      uart_rx = 1'b0;
      waitClocks(5);
      uart_rx = 1'b1;
      waitClocks(3 * CPB);
      checkStatus("glitch", 1'b0, 1'b0);
      bs = randomImage(1);
      applyStimulus(bs, eDone, eErr);
      checkStatus("after_glitch", eDone, eErr);

      // 6: reset in the middle of the second word, then resend the image
      doReset();
      bs = randomImage(2);
      modelImage(bs, eDone, eErr);
      expDoneAfterLast = eDone;
      for (int i = 0; i < 8; i++) sendByte(bs[i]);
      checkOutput("abort_pending", 32'(expQ.size()), 32'd1);
      rst_n = 1'b0;
      #1;
      checkResetState("abort");
      expQ.delete();
      waitClocks(3);
      rst_n = 1'b1;
      waitClocks(4);
      applyStimulus(bs, eDone, eErr);
      checkStatus("resend", eDone, eErr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
